delay_gen: RTL and testbench



---
 rtl/delay_gen.sv | 88 ++++++++
 tb/tb_delay_gen.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/delay_gen.sv
`timescale 1ns / 1ps
// delay_gen: reset-release delay generator.
//
// Counts rising clk_i edges after arst_ni deasserts and raises delayed_o after
// exactly COUNT_RANGE edges. delayed_o then stays high until the next reset.
// Used to hold off downstream enables/sequencing for a fixed time after reset.
//
// Parameters:
//   COUNT_RANGE  edges after reset release before delayed_o rises (1 .. 2^31-1)
//   CNT_W        counter width, derived from COUNT_RANGE; do not override
//
// Ports:
//   clk_i      input   clock, rising-edge active
//   arst_ni    input   asynchronous active-low reset
//   delayed_o  output  registered delay-elapsed flag, sticky until reset
//
// Optional build macro:
//   DELAY_GEN_ASSERT_EN  adds simulation-only concurrent assertions on the
//                        counter and flag; no functional change.

module delay_gen #(
  parameter int unsigned COUNT_RANGE = 128,
  parameter int unsigned CNT_W       = $clog2(COUNT_RANGE + 1)
) (
  input  logic clk_i,
  input  logic arst_ni,
  output logic delayed_o
);

  // Elaboration-time parameter checks.
  if (COUNT_RANGE < 1) begin : g_range_check
    $error("delay_gen: COUNT_RANGE must be at least 1");
  end
  if (CNT_W < $clog2(COUNT_RANGE + 1)) begin : g_width_check
    $error("delay_gen: CNT_W too narrow to hold COUNT_RANGE");
  end

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(COUNT_RANGE);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             delayed_q, delayed_d;

  // Counter saturates at MaxCnt; the flag is set on the edge that lands on
  // MaxCnt and is held afterwards, so it never depends on a live decode.
  always_comb begin
    cnt_d     = cnt_q;
    delayed_d = delayed_q;
    if (cnt_q < MaxCnt) begin
      cnt_d = cnt_q + OneCnt;
      if (cnt_d == MaxCnt) begin
        delayed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q     <= '0;
      delayed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      delayed_q <= delayed_d;
    end
  end

  // Output straight from the flop keeps it glitch-free.
  assign delayed_o = delayed_q;

`ifdef DELAY_GEN_ASSERT_EN
  // Flag is sticky while out of reset.
  a_sticky : assert property (@(posedge clk_i) disable iff (!arst_ni)
    delayed_q |=> delayed_q);

  // Counter saturates, never overshoots.
  a_cnt_max : assert property (@(posedge clk_i) disable iff (!arst_ni)
    cnt_q <= MaxCnt);

  // Flag rises only together with the counter reaching its limit.
  a_rise_at_max : assert property (@(posedge clk_i) disable iff (!arst_ni)
    $rose(delayed_q) |-> (cnt_q == MaxCnt));

  // Flag low while the count is still running.
  a_low_below_max : assert property (@(posedge clk_i) disable iff (!arst_ni)
    (cnt_q < MaxCnt) |-> !delayed_q);
`endif

endmodule

// File: tb/tb_delay_gen.sv
`timescale 1ns / 1ps
// tb_delay_gen: directed bench for delay_gen with three instances
// (COUNT_RANGE = 128, 1 and 1000), each with its own reset.

module tb_delay_gen;

  logic clk_i = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  logic rst_c_n = 1'b0;
  logic dly_a, dly_b, dly_c;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk_i = ~clk_i;

  delay_gen #(.COUNT_RANGE(128)) u_dut_a (
    .clk_i     (clk_i),
    .arst_ni   (rst_a_n),
    .delayed_o (dly_a)
  );

  delay_gen #(.COUNT_RANGE(1)) u_dut_b (
    .clk_i     (clk_i),
    .arst_ni   (rst_b_n),
    .delayed_o (dly_b)
  );

  delay_gen #(.COUNT_RANGE(1000)) u_dut_c (
    .clk_i     (clk_i),
    .arst_ni   (rst_c_n),
    .delayed_o (dly_c)
  );

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then step 1 ns past the last one for sampling.
  task automatic edges(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Move to 2 ns after a falling edge: well away from any rising edge.
  task automatic to_mid_low();
    @(negedge clk_i);
    #2;
  endtask

  // Check a DUT-A run from release: low through edge 127, high at edge 128.
  task automatic run_a_128(input string name);
    for (int i = 1; i <= 127; i++) begin
      edges(1);
      check_bit($sformatf("%s_low_e%0d", name, i), dly_a, 1'b0);
    end
    edges(1);
    check_bit($sformatf("%s_high_e128", name), dly_a, 1'b1);
  endtask

  initial begin
    // ---------------- Default delay, COUNT_RANGE=128 ----------------
    #1;
    check_bit("a_reset_t1", dly_a, 1'b0);
    check_bit("b_reset_t1", dly_b, 1'b0);
    check_bit("c_reset_t1", dly_c, 1'b0);
    edges(3);
    check_bit("a_reset_clocked", dly_a, 1'b0);
    check_bit("b_reset_clocked", dly_b, 1'b0);

    to_mid_low();
    rst_a_n = 1'b1;
    run_a_128("default");

    // Hold for the rest of roughly 0.5 ms.
    for (int k = 0; k < 49; k++) begin
      edges(1000);
      check_bit($sformatf("default_hold_%0d", k), dly_a, 1'b1);
    end

    // ---------------- Reset after assertion ----------------
    to_mid_low();
    rst_a_n = 1'b0;
    #1;
    check_bit("asrt_async_clear", dly_a, 1'b0);
    #99;
    check_bit("asrt_in_reset", dly_a, 1'b0);
    rst_a_n = 1'b1;
    run_a_128("asrt_restart");

    // ---------------- Reset mid-count ----------------
    to_mid_low();
    rst_a_n = 1'b0;
    #10;
    rst_a_n = 1'b1;
    edges(60);
    check_bit("mid_low_e60", dly_a, 1'b0);
    to_mid_low();
    rst_a_n = 1'b0;
    #1;
    check_bit("mid_in_reset", dly_a, 1'b0);
    #9;
    rst_a_n = 1'b1;
    edges(68);
    check_bit("mid_low_e68", dly_a, 1'b0);
    edges(59);
    check_bit("mid_low_e127", dly_a, 1'b0);
    edges(1);
    check_bit("mid_high_e128", dly_a, 1'b1);

    // ---------------- Minimum range, COUNT_RANGE=1 ----------------
    check_bit("min_reset", dly_b, 1'b0);
    to_mid_low();
    rst_b_n = 1'b1;
    #1;
    check_bit("min_released_no_edge", dly_b, 1'b0);
    edges(1);
    check_bit("min_high_e1", dly_b, 1'b1);
    edges(10);
    check_bit("min_hold", dly_b, 1'b1);

    // ---------------- Non-power-of-two, COUNT_RANGE=1000 ----------------
    check_bit("np2_reset", dly_c, 1'b0);
    to_mid_low();
    rst_c_n = 1'b1;
    edges(1);
    check_bit("np2_low_e1", dly_c, 1'b0);
    edges(511);
    check_bit("np2_low_e512", dly_c, 1'b0);
    edges(487);
    check_bit("np2_low_e999", dly_c, 1'b0);
    edges(1);
    check_bit("np2_high_e1000", dly_c, 1'b1);
    for (int k = 0; k < 20; k++) begin
      edges(250);
      check_bit($sformatf("np2_sat_%0d", k), dly_c, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
